switch_debouncer: RTL



---
 rtl/debounce_pkg.sv | 10 +
 rtl/sync_ff.sv | 16 +
 rtl/switch_debouncer.sv | 81 ++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and limits for input-conditioning blocks
package debounce_pkg;
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } state_t;
    localparam int DEBOUNCE_CYCLES_MIN = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: DEPTH-flop synchroniser, async active-low reset to 0
// Ports: clk (clock), rst_n (async active-low reset), d (async input), q (synchronised output)
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] chain;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain <= '0;
        else        chain <= {chain[DEPTH-2:0], d};
    assign q = chain[DEPTH-1];
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises and debounces a raw switch level into w, with a w_rise pulse
// Ports: Clock, Resetn (async active-low), sw_raw (raw bouncing level),
//        w (debounced level), w_rise (one-cycle pulse on the cycle w goes 0->1)
// Macro SWITCH_DEBOUNCER_SYNC3_EN selects a three-flop synchroniser (one extra cycle of latency).
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic sw_raw,
    output logic w,
    output logic w_rise
);
`ifdef SWITCH_DEBOUNCER_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_cfg
        $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end

    logic s;
    logic done;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    sync_ff #(.DEPTH(SYNC_DEPTH)) u_sync (
        .clk  (Clock),
        .rst_n(Resetn),
        .d    (sw_raw),
        .q    (s)
    );

    assign done = cnt == TERM;

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            w_rise <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            w_rise <= (state == WAIT_HI) && (state_nx == STABLE_HI);
        end

    // A level opposite to the settled one must persist through the terminal count;
    // any sample back at the settled level abandons the pending change.
    always_comb begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
        case (state)
            STABLE_LO: begin
                state_nx = s ? WAIT_HI : STABLE_LO;
                cnt_nx   = s ? ONE : '0;
            end
            WAIT_HI: begin
                state_nx = !s ? STABLE_LO : done ? STABLE_HI : WAIT_HI;
                cnt_nx   = (s && !done) ? cnt + ONE : '0;
            end
            STABLE_HI: begin
                state_nx = s ? STABLE_HI : WAIT_LO;
                cnt_nx   = s ? '0 : ONE;
            end
            WAIT_LO: begin
                state_nx = s ? STABLE_HI : done ? STABLE_LO : WAIT_LO;
                cnt_nx   = (!s && !done) ? cnt + ONE : '0;
            end
            default: ;
        endcase
    end

    always_comb w = (state == STABLE_HI) || (state == WAIT_LO);
endmodule
